// File: rtl/key_step_gen.sv
// Button conditioner for the LFSR demo: 2-flop sync, debounce FSM, one-cycle step pulses, step counter.
// Define AUTO_REPEAT_EN to add hold-to-repeat steps (REPEAT_DELAY, then every REPEAT_PERIOD).
module key_step_gen #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int REPEAT_DELAY    = 64,
    parameter int REPEAT_PERIOD   = 16,
    parameter int CNT_W           = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_raw,
    output logic       step,
    output logic       btn_level,
    output logic [7:0] step_count
);

    typedef enum logic [1:0] {IDLE, PRESS_DB, HELD, REL_DB} state_t;

    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    // Elaboration-time sanity check of the configuration.
    if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES >= (2 ** CNT_W) ||
        REPEAT_DELAY < 2 || REPEAT_PERIOD < 2 ||
        REPEAT_DELAY >= (2 ** CNT_W) || REPEAT_PERIOD >= (2 ** CNT_W)) begin : g_bad_cfg
        $error("key_step_gen: illegal parameter combination");
    end

    state_t           state, state_nx;
    logic             s1, btn_s;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic             step_nx, level_nx;
    logic             rpt_fire;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1    <= 1'b0;
            btn_s <= 1'b0;
        end else begin
            s1    <= btn_raw;
            btn_s <= s1;
        end
    end

`ifdef AUTO_REPEAT_EN
    // rpt_phase=0 waits out the initial delay, rpt_phase=1 paces the steady repeats.
    logic [CNT_W-1:0] rpt_cnt;
    logic             rpt_phase;
    logic [CNT_W-1:0] rpt_target;

    assign rpt_target = rpt_phase ? CNT_W'(REPEAT_PERIOD) : CNT_W'(REPEAT_DELAY);
    assign rpt_fire   = (state == HELD) && btn_s && (rpt_cnt == rpt_target);

    always_ff @(posedge clk) begin
        if (rst || state_nx == IDLE) begin
            rpt_cnt   <= '0;
            rpt_phase <= 1'b0;
        end else if (state == PRESS_DB && state_nx == HELD) begin
            rpt_cnt   <= ONE;
            rpt_phase <= 1'b0;
        end else if (state == HELD && state_nx == HELD) begin
            if (rpt_fire) begin
                rpt_cnt   <= ONE;
                rpt_phase <= 1'b1;
            end else begin
                rpt_cnt <= rpt_cnt + ONE;
            end
        end
    end
`else
    assign rpt_fire = 1'b0;
`endif

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        step_nx  = 1'b0;
        level_nx = btn_level;
        case (state)
            IDLE: begin
                level_nx = 1'b0;
                if (btn_s) begin
                    state_nx = PRESS_DB;
                    cnt_nx   = ONE;
                end
            end
            PRESS_DB: begin
                level_nx = 1'b0;
                if (!btn_s) begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end else if (cnt == DB_LAST) begin
                    state_nx = HELD;
                    cnt_nx   = '0;
                    step_nx  = 1'b1;
                    level_nx = 1'b1;
                end else begin
                    cnt_nx = cnt + ONE;
                end
            end
            HELD: begin
                level_nx = 1'b1;
                if (!btn_s) begin
                    state_nx = REL_DB;
                    cnt_nx   = ONE;
                end else if (rpt_fire) begin
                    step_nx = 1'b1;
                end
            end
            REL_DB: begin
                level_nx = 1'b1;
                if (btn_s) begin
                    // Release glitch: back to HELD without a fresh step.
                    state_nx = HELD;
                    cnt_nx   = '0;
                end else if (cnt == DB_LAST) begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                    level_nx = 1'b0;
                end else begin
                    cnt_nx = cnt + ONE;
                end
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = '0;
                level_nx = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            step       <= 1'b0;
            btn_level  <= 1'b0;
            step_count <= '0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            step      <= step_nx;
            btn_level <= level_nx;
            if (step_nx)
                step_count <= step_count + 8'd1;
        end
    end

endmodule
